// File: rtl/mux3_rr_arbiter_if.sv
// Handshake bundle between the three requesters and the mux-select arbiter.
// The master side owns the request lines; the slave side (the arbiter)
// returns the one-hot grant and the matching mux select.
interface mux3_rr_arbiter_if;
  logic [2:0] req;        // bit0=a, bit1=b, bit2=c; level-sensitive
  logic [2:0] gnt;        // one-hot grant, zero when idle
  logic [1:0] sel;        // mux select 0/1/2 for a/b/c
  logic       sel_valid;  // sel is meaningful only while high

  modport master (output req, input gnt, sel, sel_valid);
  modport slave  (input req, output gnt, sel, sel_valid);
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one 3-input mux between requesters a/b/c.
// Grant, select and valid are all registered (one cycle from req to gnt).
// A burst limit forces the owner to pass the grant on once it has held it
// for MAX_BURST cycles while a competitor waits; MAX_BURST=0 disables this.
module mux3_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3   // must hold MAX_BURST
) (
  input  logic               clk,
  input  logic               rst,
  mux3_rr_arbiter_if.slave   arb
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       others;      // pending requests excluding the current owner
  logic             burst_done;  // owner has used up its burst allowance
  logic [1:0]       after_owner; // first index searched when the owner leaves
  logic [1:0]       win;

  // Successor in the rotation a -> b -> c -> a.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // First requester set in r when scanning start, start+1, start+2 (mod 3).
  // Scanning backwards lets the earliest hit overwrite later ones.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    res = start;
    for (int k = 2; k >= 0; k--) begin
      idx = start;
      for (int s = 0; s < k; s++) idx = next_idx(idx);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  assign others      = arb.req & ~gnt_q;
  assign burst_done  = (MAX_BURST != 0) && (cnt_q == MAX_CNT);
  assign after_owner = next_idx(sel_q);

  // Next-state and next-output decision from the current request and state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    win     = 2'd0;

    case (state_q)
      IDLE: begin
        if (arb.req != 3'b000) begin
          win     = pick(arb.req, ptr_q);
          state_d = GRANT;
          gnt_d   = 3'b001 << win;
          sel_d   = win;
          valid_d = 1'b1;
          cnt_d   = CNT_ONE;
        end
      end

      GRANT: begin
        if (!arb.req[sel_q] || (burst_done && others != 3'b000)) begin
          // Release or forced rotate: the owner is excluded from this search.
          ptr_d = after_owner;
          if (others != 3'b000) begin
            win   = pick(others, after_owner);
            gnt_d = 3'b001 << win;
            sel_d = win;
            cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
            valid_d = 1'b0;
          end
        end else if (MAX_BURST != 0 && cnt_q != MAX_CNT) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.sel       = sel_q;
  assign arb.sel_valid = valid_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed bench for mux3_rr_arbiter: one instance with MAX_BURST=4 and one
// with MAX_BURST=0, sharing clock and reset. Expected values are hand-derived.
module tb_mux3_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mux3_rr_arbiter_if if_a ();
  mux3_rr_arbiter_if if_b ();

  mux3_rr_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .arb (if_a)
  );

  mux3_rr_arbiter #(.MAX_BURST(0), .CNT_W(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .arb (if_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [2:0] g, input logic [1:0] s, input logic v);
    check({tag, ".gnt"},       if_a.gnt,       g);
    check({tag, ".sel"},       if_a.sel,       s);
    check({tag, ".sel_valid"}, if_a.sel_valid, v);
  endtask

  // Advance one rising edge and settle 1ns past it; inputs change here too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] exp_g;
  logic [1:0] exp_s;

  initial begin
    if_a.req = 3'b000;
    if_b.req = 3'b000;

    // Reset state
    #12;
    check_a("reset", 3'b000, 2'd0, 1'b0);
    check("reset_b.gnt", if_b.gnt, 3'b000);
    rst = 1'b0;
    step();

    // All three requesting: 4 cycles each in order a, b, c, then a again
    if_a.req = 3'b111;
    for (int i = 1; i <= 13; i++) begin
      step();
      exp_s = 2'(((i - 1) / 4) % 3);
      exp_g = 3'b001 << exp_s;
      check_a($sformatf("rr111_c%0d", i), exp_g, exp_s, 1'b1);
    end

    // Drop all: back to idle, sel holds a
    if_a.req = 3'b000;
    step();
    check_a("rr_idle", 3'b000, 2'd0, 1'b0);

    // b alone for 3 cycles, then release; sel stays 1 while idle
    if_a.req = 3'b010;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_a($sformatf("b_only_c%0d", i), 3'b010, 2'd1, 1'b1);
    end
    if_a.req = 3'b000;
    step();
    check_a("b_release_idle", 3'b000, 2'd1, 1'b0);

    // ptr now points at c, so a wins over b
    if_a.req = 3'b011;
    step();
    check_a("ptr_after_b", 3'b001, 2'd0, 1'b1);
    if_a.req = 3'b000;
    step();
    check_a("idle2", 3'b000, 2'd0, 1'b0);

    // a alone for 10 cycles keeps the grant past the burst limit
    if_a.req = 3'b001;
    for (int i = 1; i <= 10; i++) begin
      step();
      check_a($sformatf("a_alone_c%0d", i), 3'b001, 2'd0, 1'b1);
    end
    // c appears: saturated count rotates on the very next edge
    if_a.req = 3'b101;
    step();
    check_a("a_preempt_by_c", 3'b100, 2'd2, 1'b1);

    // c releases with b pending: b owns the grant
    if_a.req = 3'b010;
    step();
    check_a("c_to_b", 3'b010, 2'd1, 1'b1);

    // b drops while a and c rise: straight to c, no idle cycle
    if_a.req = 3'b101;
    step();
    check_a("b_to_c_no_idle", 3'b100, 2'd2, 1'b1);

    // Asynchronous reset mid-grant clears outputs before the next edge
    #2;
    rst = 1'b1;
    #1;
    check_a("async_rst", 3'b000, 2'd0, 1'b0);
    if_a.req = 3'b110;
    #2;
    rst = 1'b0;
    step();
    check_a("post_rst_b_first", 3'b010, 2'd1, 1'b1);

    // Unlimited burst: a holds for 20 cycles under full contention
    if_b.req = 3'b111;
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("unl_c%0d.gnt", i), if_b.gnt, 3'b001);
    end
    if_b.req = 3'b110;
    step();
    check("unl_release.gnt", if_b.gnt, 3'b010);
    check("unl_release.sel", if_b.sel, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000ns");
    $fatal(1, "timeout");
  end

endmodule
